// File: rtl/fft_reorder_pkg.sv
// Shared FFT helpers: bin-index bit reversal and the reorder read-side FSM state type.
package fft_reorder_pkg;

    typedef enum logic {
        RdIdle,
        RdRead
    } rd_state_e;

    // Reverses the low n_bits of value; bits above n_bits come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned n_bits);
        logic [31:0] rev;
        rev = {<<{value}};
        return rev >> (32 - n_bits);
    endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM with a registered read port; contents are never reset.
module fft_reorder_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SIZE  = 16
) (
    input  logic                    wrclk,
    input  logic                    i_wr_en,
    input  logic [$clog2(SIZE)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]        i_wr_data,
    input  logic                    rdclk,
    input  logic                    i_rd_en,
    input  logic [$clog2(SIZE)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]        o_rd_data
);

    logic [WIDTH-1:0] r_mem [SIZE];

    always_ff @(posedge wrclk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge rdclk) begin
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer: takes bit-reversed FFT output frames and re-emits them in
// natural bin order, dropping partial frames and flagging bin-index misalignment.
module fft_reorder
    import fft_reorder_pkg::*;
#(
    parameter int unsigned N          = 1024,
    parameter int unsigned DATA_WIDTH = 25
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  sync_i,
    input  logic [$clog2(N)-1:0]  ctr_i,
    input  logic [DATA_WIDTH-1:0] re_i,
    input  logic [DATA_WIDTH-1:0] im_i,
    output logic                  valid_o,
    output logic [$clog2(N)-1:0]  ctr_o,
    output logic [DATA_WIDTH-1:0] re_o,
    output logic [DATA_WIDTH-1:0] im_o,
    output logic                  last_o,
    output logic                  err_o
);

    localparam int unsigned       N_LOG2  = $clog2(N);
    localparam int unsigned       WordW   = 2 * DATA_WIDTH;
    localparam logic [N_LOG2-1:0] LastBin = N_LOG2'(N - 1);

    logic [N_LOG2-1:0]     r_wr_cnt;
    logic                  r_wr_bank;
    logic                  r_err;
    rd_state_e             r_rd_state;
    logic [N_LOG2-1:0]     r_rd_cnt;
    logic                  r_rd_bank;
    logic                  r_p1_vld;
    logic [N_LOG2-1:0]     r_p1_ctr;
    logic                  r_valid;
    logic                  r_last;
    logic [N_LOG2-1:0]     r_ctr;
    logic [DATA_WIDTH-1:0] r_re;
    logic [DATA_WIDTH-1:0] r_im;

    logic              w_frame_done;
    logic              w_misaligned;
    logic              w_rd_en;
    logic [N_LOG2:0]   w_wr_addr;
    logic [N_LOG2:0]   w_rd_addr;
    logic [WordW-1:0]  w_rd_data;

    assign w_frame_done = sync_i && (r_wr_cnt == LastBin);
    assign w_misaligned = sync_i && (32'(ctr_i) != bitrev(32'(r_wr_cnt), N_LOG2));
    assign w_rd_en      = (r_rd_state == RdRead);
    assign w_wr_addr    = {r_wr_bank, ctr_i};
    assign w_rd_addr    = {r_rd_bank, r_rd_cnt};

    // Write side; dropping sync_i mid-frame rewinds the count so the same bank is reused.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_frame_done) begin
                r_wr_cnt  <= '0;
                r_wr_bank <= ~r_wr_bank;
            end else if (sync_i) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end else begin
                r_wr_cnt <= '0;
            end
            if (w_misaligned) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            r_rd_state <= RdIdle;
            r_rd_cnt   <= '0;
            r_rd_bank  <= 1'b0;
            r_p1_vld   <= 1'b0;
            r_p1_ctr   <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_ctr      <= '0;
            r_re       <= '0;
            r_im       <= '0;
        end else begin
            // A completion can only coincide with the final read address, giving a seamless restart.
            if (w_frame_done) begin
                r_rd_state <= RdRead;
                r_rd_cnt   <= '0;
                r_rd_bank  <= r_wr_bank;
            end else if (r_rd_state == RdRead) begin
                if (r_rd_cnt == LastBin) begin
                    r_rd_state <= RdIdle;
                    r_rd_cnt   <= '0;
                end else begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end
            r_p1_vld <= w_rd_en;
            r_p1_ctr <= r_rd_cnt;
            r_valid  <= r_p1_vld;
            r_last   <= r_p1_vld && (r_p1_ctr == LastBin);
            if (r_p1_vld) begin
                r_ctr <= r_p1_ctr;
                r_re  <= w_rd_data[WordW-1:DATA_WIDTH];
                r_im  <= w_rd_data[DATA_WIDTH-1:0];
            end
        end
    end

    fft_reorder_ram #(
        .WIDTH (WordW),
        .SIZE  (2 * N)
    ) u_ram (
        .wrclk     (clk_i),
        .i_wr_en   (sync_i),
        .i_wr_addr (w_wr_addr),
        .i_wr_data ({re_i, im_i}),
        .rdclk     (clk_i),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign valid_o = r_valid;
    assign ctr_o   = r_ctr;
    assign re_o    = r_re;
    assign im_o    = r_im;
    assign last_o  = r_last;
    assign err_o   = r_err;

endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder at N=16, DATA_WIDTH=8: table of per-bin stimulus/expectations.
module tb_fft_reorder;

    localparam int unsigned N  = 16;
    localparam int unsigned DW = 8;

    typedef struct {
        logic [3:0] ctr_in;
        logic [7:0] re_in;
        logic [7:0] im_in;
        logic [3:0] ctr_exp;
        logic [7:0] re_exp;
        logic [7:0] im_exp;
        logic       last_exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sync_i;
    logic [3:0]    ctr_i;
    logic [DW-1:0] re_i;
    logic [DW-1:0] im_i;
    logic          valid_o;
    logic [3:0]    ctr_o;
    logic [DW-1:0] re_o;
    logic [DW-1:0] im_o;
    logic          last_o;
    logic          err_o;

    vec_t tbl [16];
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    fft_reorder #(
        .N          (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i   (clk),
        .rst_n   (rst_n),
        .sync_i  (sync_i),
        .ctr_i   (ctr_i),
        .re_i    (re_i),
        .im_i    (im_i),
        .valid_o (valid_o),
        .ctr_o   (ctr_o),
        .re_o    (re_o),
        .im_o    (im_o),
        .last_o  (last_o),
        .err_o   (err_o)
    );

    function automatic logic [3:0] br4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_valid"}, 32'(valid_o), 32'd0);
        chk({nm, "_last"}, 32'(last_o), 32'd0);
        chk({nm, "_err"}, 32'(err_o), 32'd0);
        chk({nm, "_ctr"}, 32'(ctr_o), 32'd0);
        chk({nm, "_re"}, 32'(re_o), 32'd0);
        chk({nm, "_im"}, 32'(im_o), 32'd0);
    endtask

    // quiet: 0 no checks, 1 valid_o must stay low, 2 all outputs at reset values.
    task automatic feed(input logic [7:0] off, input int nsamp, input bit swap34, input int quiet);
        for (int i = 0; i < nsamp; i++) begin
            int k;
            k = (swap34 && i == 3) ? 4 : (swap34 && i == 4) ? 3 : i;
            sync_i = 1'b1;
            ctr_i  = tbl[k].ctr_in;
            re_i   = tbl[k].re_in + off;
            im_i   = tbl[k].im_in;
            tick();
            if (quiet == 1) chk("capture_quiet_valid", 32'(valid_o), 32'd0);
            if (quiet == 2) chk_reset("capture_quiet");
        end
    endtask

    task automatic check_bins(input logic [7:0] off, input string nm);
        for (int b = 0; b < 16; b++) begin
            logic [7:0] re_e;
            re_e = tbl[b].re_exp + off;
            chk({nm, "_valid"}, 32'(valid_o), 32'd1);
            chk({nm, "_ctr"}, 32'(ctr_o), 32'(tbl[b].ctr_exp));
            chk({nm, "_re"}, 32'(re_o), 32'(re_e));
            chk({nm, "_im"}, 32'(im_o), 32'(tbl[b].im_exp));
            chk({nm, "_last"}, 32'(last_o), 32'(tbl[b].last_exp));
            tick();
        end
    endtask

    // Called right after the tick that sampled the last input of a frame.
    task automatic finish_frame(input logic [7:0] off, input string nm);
        sync_i = 1'b0;
        tick();
        chk({nm, "_latency_valid"}, 32'(valid_o), 32'd0);
        tick();
        check_bins(off, nm);
        chk({nm, "_after_valid"}, 32'(valid_o), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i].ctr_in   = br4(4'(i));
            tbl[i].re_in    = 8'(br4(4'(i)));
            tbl[i].im_in    = 8'(0) - 8'(br4(4'(i)));
            tbl[i].ctr_exp  = 4'(i);
            tbl[i].re_exp   = 8'(i);
            tbl[i].im_exp   = 8'(0) - 8'(i);
            tbl[i].last_exp = (i == 15);
        end

        rst_n  = 1'b0;
        sync_i = 1'b0;
        ctr_i  = '0;
        re_i   = '0;
        im_i   = '0;
        tick();
        tick();
        chk_reset("reset");
        rst_n = 1'b1;
        tick();
        chk_reset("reset_release");

        // Nominal single frame.
        feed(8'h00, 16, 1'b0, 0);
        finish_frame(8'h00, "nominal");
        chk("nominal_err", 32'(err_o), 32'd0);

        // Three back-to-back frames: valid_o must not drop between them.
        fork
            begin
                feed(8'h00, 16, 1'b0, 0);
                feed(8'h20, 16, 1'b0, 0);
                feed(8'h40, 16, 1'b0, 0);
                sync_i = 1'b0;
            end
            begin
                repeat (17) tick();
                chk("stream_latency_valid", 32'(valid_o), 32'd0);
                tick();
                check_bins(8'h00, "stream0");
                check_bins(8'h20, "stream1");
                check_bins(8'h40, "stream2");
                chk("stream_after_valid", 32'(valid_o), 32'd0);
            end
        join

        // Partial frame is abandoned; only the following full frame comes out.
        feed(8'h70, 7, 1'b0, 0);
        sync_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("partial_gap_valid", 32'(valid_o), 32'd0);
        end
        feed(8'h30, 16, 1'b0, 1);
        finish_frame(8'h30, "partial_full");

        // Swapped bins on samples 3 and 4: err_o rises on sample 3 and sticks.
        for (int i = 0; i < 16; i++) begin
            int k;
            k = (i == 3) ? 4 : (i == 4) ? 3 : i;
            sync_i = 1'b1;
            ctr_i  = tbl[k].ctr_in;
            re_i   = tbl[k].re_in + 8'h08;
            im_i   = tbl[k].im_in;
            tick();
            chk("misalign_err", 32'(err_o), 32'(i >= 3));
        end
        finish_frame(8'h08, "misalign");
        feed(8'h18, 16, 1'b0, 0);
        finish_frame(8'h18, "clean_after_err");
        chk("err_sticky", 32'(err_o), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset("err_cleared");

        // Reset while bin 5 is on the output.
        feed(8'h50, 16, 1'b0, 0);
        sync_i = 1'b0;
        tick();
        tick();
        for (int b = 0; b < 5; b++) begin
            chk("rdrst_pre_ctr", 32'(ctr_o), 32'(b));
            tick();
        end
        chk("rdrst_bin5_ctr", 32'(ctr_o), 32'd5);
        chk("rdrst_bin5_valid", 32'(valid_o), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset("rdrst");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_reset("rdrst_idle");
        end
        feed(8'h10, 16, 1'b0, 2);
        finish_frame(8'h10, "post_rdrst");

        // Reset after ten captured samples.
        feed(8'h60, 10, 1'b0, 0);
        sync_i = 1'b0;
        rst_n  = 1'b0;
        tick();
        rst_n = 1'b1;
        chk_reset("caprst");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_reset("caprst_idle");
        end
        feed(8'h20, 16, 1'b0, 2);
        finish_frame(8'h20, "post_caprst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
